fp_exception_unit: RTL and testbench

FP_EXCEPTION_UNIT -- requirements
Module: fp_exception_unit

---
 rtl/fp_exception_unit_if.sv | 42 ++++
 rtl/fp_exception_unit.sv | 197 +++++++++++++++++++
 tb/tb_fp_exception_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_exception_unit_if.sv
// Handshake and data bundle for fp_exception_unit.
// master = producer/consumer side (testbench or host), slave = the unit.
interface fp_exception_unit_if #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 8
);
  localparam int W = 1 + EXP_W + MAN_W;

  // request side
  logic             IN_VALID;
  logic             IN_READY;
  logic [1:0]       FP_OPERATION;
  logic [W-1:0]     OP_A;
  logic [W-1:0]     OP_B;

  // result side
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OP_IS_EXCEPTION;
  logic             FLAG_INVALID;
  logic             FLAG_DIVZERO;
  logic             FLAG_NAN_IN;
  logic [W-1:0]     RESULT_DEFAULT;

  // accumulated status
  logic             CLR_STICKY;
  logic [2:0]       STICKY_FLAGS;
  logic [CNT_W-1:0] EXC_COUNT;

  modport master (
    output IN_VALID, FP_OPERATION, OP_A, OP_B, OUT_READY, CLR_STICKY,
    input  IN_READY, OUT_VALID, OP_IS_EXCEPTION, FLAG_INVALID, FLAG_DIVZERO,
           FLAG_NAN_IN, RESULT_DEFAULT, STICKY_FLAGS, EXC_COUNT
  );

  modport slave (
    input  IN_VALID, FP_OPERATION, OP_A, OP_B, OUT_READY, CLR_STICKY,
    output IN_READY, OUT_VALID, OP_IS_EXCEPTION, FLAG_INVALID, FLAG_DIVZERO,
           FLAG_NAN_IN, RESULT_DEFAULT, STICKY_FLAGS, EXC_COUNT
  );
endinterface

// File: rtl/fp_exception_unit.sv
// Floating-point exception classifier: flags invalid / divide-by-zero /
// NaN-input for add, sub, mul and div, produces the default result, and
// keeps sticky flags plus a saturating exception counter. One-deep
// registered output stage with valid/ready handshake.
module fp_exception_unit #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  fp_exception_unit_if.slave   bus
);

  localparam int W = 1 + EXP_W + MAN_W;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_e;

  state_e state_q, state_d;

  logic in_ready;
  logic out_valid;
  logic accept;

  // operand fields and classes
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             a_nan, a_inf, a_zero, a_fin;
  logic             b_nan, b_inf, b_zero, b_fin;

  // combinational classification of the presented transaction
  logic             nan_in_c;
  logic             invalid_c;
  logic             divzero_c;
  logic             inv_raw;
  logic [W-1:0]     result_c;
  logic [W-1:0]     qnan_c;
  logic [W-1:0]     inf_c;
  op_e              op;

  // registered result stage
  logic             flag_invalid_q;
  logic             flag_divzero_q;
  logic             flag_nan_q;
  logic [W-1:0]     result_q;

  // accumulated status
  logic [2:0]       sticky_q;
  logic [2:0]       sticky_base;
  logic [2:0]       new_flags;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_base;

  // Operand field extraction and class decode
  always_comb begin
    sign_a = bus.OP_A[W-1];
    sign_b = bus.OP_B[W-1];
    exp_a  = bus.OP_A[W-2 -: EXP_W];
    exp_b  = bus.OP_B[W-2 -: EXP_W];
    man_a  = bus.OP_A[MAN_W-1:0];
    man_b  = bus.OP_B[MAN_W-1:0];

    a_nan  = (&exp_a) && (|man_a);
    a_inf  = (&exp_a) && !(|man_a);
    a_zero = !(|exp_a) && !(|man_a);
    a_fin  = !a_nan && !a_inf && !a_zero;

    b_nan  = (&exp_b) && (|man_b);
    b_inf  = (&exp_b) && !(|man_b);
    b_zero = !(|exp_b) && !(|man_b);
    b_fin  = !b_nan && !b_inf && !b_zero;
  end

  // Exception rules per operation; a NaN input masks the other two flags
  always_comb begin
    op       = op_e'(bus.FP_OPERATION);
    nan_in_c = a_nan || b_nan;
    inv_raw  = 1'b0;
    divzero_c = 1'b0;
    case (op)
      OP_ADD: inv_raw = a_inf && b_inf && (sign_a != sign_b);
      OP_SUB: inv_raw = a_inf && b_inf && (sign_a == sign_b);
      OP_MUL: inv_raw = (a_zero && b_inf) || (a_inf && b_zero);
      OP_DIV: begin
        inv_raw   = (a_zero && b_zero) || (a_inf && b_inf);
        divzero_c = b_zero && a_fin && !nan_in_c;
      end
      default: inv_raw = 1'b0;
    endcase
    invalid_c = inv_raw && !nan_in_c;
  end

  // Default result: canonical quiet NaN, signed infinity, or zero
  always_comb begin
    qnan_c               = '0;
    qnan_c[W-2 -: EXP_W] = '1;
    qnan_c[MAN_W-1]      = 1'b1;

    inf_c                = '0;
    inf_c[W-2 -: EXP_W]  = '1;
    inf_c[W-1]           = sign_a ^ sign_b;

    if (invalid_c || nan_in_c) begin
      result_c = qnan_c;
    end else if (divzero_c) begin
      result_c = inf_c;
    end else begin
      result_c = '0;
    end
  end

  // Output-stage occupancy register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: fill on accept, drain on consume without refill
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (bus.OUT_READY && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Handshake outputs derived from occupancy
  always_comb begin
    out_valid = (state_q == S_FULL);
    in_ready  = (state_q == S_EMPTY) || bus.OUT_READY;
    accept    = bus.IN_VALID && in_ready;
  end

  // Result registers load only on an accepted transfer
  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_invalid_q <= 1'b0;
      flag_divzero_q <= 1'b0;
      flag_nan_q     <= 1'b0;
      result_q       <= '0;
    end else if (accept) begin
      flag_invalid_q <= invalid_c;
      flag_divzero_q <= divzero_c;
      flag_nan_q     <= nan_in_c;
      result_q       <= result_c;
    end
  end

  // Clear is applied before the new transaction is folded in, so a
  // same-cycle clear and exception leaves exactly that exception recorded.
  always_comb begin
    sticky_base = bus.CLR_STICKY ? 3'b000 : sticky_q;
    cnt_base    = bus.CLR_STICKY ? '0 : cnt_q;
    new_flags   = accept ? {nan_in_c, divzero_c, invalid_c} : 3'b000;
  end

  // Sticky flags and saturating exception counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      sticky_q <= 3'b000;
      cnt_q    <= '0;
    end else if (bus.CLR_STICKY || accept) begin
      sticky_q <= sticky_base | new_flags;
      if ((|new_flags) && (cnt_base != '1)) begin
        cnt_q <= cnt_base + CNT_W'(1);
      end else begin
        cnt_q <= cnt_base;
      end
    end
  end

  assign bus.IN_READY        = in_ready;
  assign bus.OUT_VALID       = out_valid;
  assign bus.FLAG_INVALID    = flag_invalid_q;
  assign bus.FLAG_DIVZERO    = flag_divzero_q;
  assign bus.FLAG_NAN_IN     = flag_nan_q;
  assign bus.OP_IS_EXCEPTION = flag_invalid_q | flag_divzero_q | flag_nan_q;
  assign bus.RESULT_DEFAULT  = result_q;
  assign bus.STICKY_FLAGS    = sticky_q;
  assign bus.EXC_COUNT       = cnt_q;

endmodule

// File: tb/tb_fp_exception_unit.sv
// Self-checking bench for fp_exception_unit: directed vectors, handshake
// backpressure, throughput, counter saturation, reset, and randomized
// traffic against a behavioural model.
module tb_fp_exception_unit;

  localparam int EXP_W  = 4;
  localparam int MAN_W  = 3;
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int CNT_W  = 8;
  localparam int CNT_W2 = 2;
  localparam int EMAX   = (1 << EXP_W) - 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  localparam int K_ZERO = 0;
  localparam int K_FIN  = 1;
  localparam int K_INF  = 2;
  localparam int K_NAN  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_exception_unit_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W))  bus ();
  fp_exception_unit_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W2)) bus2 ();

  fp_exception_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  fp_exception_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W2)) dut2 (
    .CLK (clk),
    .RST (rst),
    .bus (bus2)
  );

  int errors = 0;
  int checks = 0;

  typedef logic [24:0] obs_t;

  typedef struct packed {
    logic         nan;
    logic         inv;
    logic         dz;
    logic [W-1:0] res;
  } ref_t;

  // behavioural model state for the randomized run
  logic       m_valid;
  ref_t       m_out;
  logic [2:0] m_sticky;
  int         m_cnt;

  function automatic obs_t obs();
    return {bus.OUT_VALID, bus.IN_READY, bus.OP_IS_EXCEPTION, bus.FLAG_INVALID,
            bus.FLAG_DIVZERO, bus.FLAG_NAN_IN, bus.RESULT_DEFAULT,
            bus.STICKY_FLAGS, bus.EXC_COUNT};
  endfunction

  function automatic obs_t pack(logic ov, logic ir, logic inv, logic dz, logic nan,
                                logic [7:0] res, logic [2:0] st, logic [7:0] cnt);
    return {ov, ir, inv | dz | nan, inv, dz, nan, res, st, cnt};
  endfunction

  function automatic int kind_of(int x);
    int e, m;
    e = (x / (1 << MAN_W)) % (1 << EXP_W);
    m = x % (1 << MAN_W);
    if (e == EMAX) return (m != 0) ? K_NAN : K_INF;
    if (e == 0 && m == 0) return K_ZERO;
    return K_FIN;
  endfunction

  // Reference classification straight from the IEEE exception rules
  function automatic ref_t ref_model(int op, int a, int b);
    ref_t r;
    int ka, kb, sa, sb;
    ka = kind_of(a);
    kb = kind_of(b);
    sa = a / (1 << (W - 1));
    sb = b / (1 << (W - 1));
    r = '0;
    if (ka == K_NAN || kb == K_NAN) begin
      r.nan = 1'b1;
    end else begin
      case (op)
        0: r.inv = (ka == K_INF && kb == K_INF && sa != sb);
        1: r.inv = (ka == K_INF && kb == K_INF && sa == sb);
        2: r.inv = (ka == K_ZERO && kb == K_INF) || (ka == K_INF && kb == K_ZERO);
        default: begin
          r.inv = (ka == K_ZERO && kb == K_ZERO) || (ka == K_INF && kb == K_INF);
          r.dz  = (kb == K_ZERO && ka == K_FIN);
        end
      endcase
    end
    if (r.nan || r.inv)
      r.res = W'(EMAX * (1 << MAN_W) + (1 << (MAN_W - 1)));
    else if (r.dz)
      r.res = W'((((sa + sb) % 2) << (W - 1)) + EMAX * (1 << MAN_W));
    else
      r.res = '0;
    return r;
  endfunction

  function automatic logic [7:0] pick_operand();
    logic [7:0] specials [9];
    specials = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h79, 8'hFF, 8'h38, 8'hB8, 8'h01};
    if ($urandom_range(0, 1) == 0)
      return specials[$urandom_range(0, 8)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic idle();
    bus.IN_VALID = 1'b0;  bus.OUT_READY = 1'b0;  bus.CLR_STICKY = 1'b0;
    bus.FP_OPERATION = 2'b00;  bus.OP_A = '0;  bus.OP_B = '0;
    bus2.IN_VALID = 1'b0; bus2.OUT_READY = 1'b0; bus2.CLR_STICKY = 1'b0;
    bus2.FP_OPERATION = 2'b00; bus2.OP_A = '0; bus2.OP_B = '0;
  endtask

  task automatic drive(logic v, logic rdy, logic [1:0] op, logic [7:0] a, logic [7:0] b);
    bus.IN_VALID = v; bus.OUT_READY = rdy; bus.FP_OPERATION = op;
    bus.OP_A = a; bus.OP_B = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== pack(0, 1, 0, 0, 0, 8'h00, 3'b000, 8'h00)) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs(), pack(0, 1, 0, 0, 0, 8'h00, 3'b000, 8'h00));
    end
  endtask

  task automatic test_directed();
    typedef struct packed {
      logic [1:0] op; logic [7:0] a; logic [7:0] b;
      logic inv; logic dz; logic nan; logic [7:0] res;
    } vec_t;
    vec_t vecs [9];
    vecs = '{
      '{2'd0, 8'h78, 8'hF8, 1'b1, 1'b0, 1'b0, 8'h7C},
      '{2'd0, 8'h78, 8'h78, 1'b0, 1'b0, 1'b0, 8'h00},
      '{2'd1, 8'hF8, 8'hF8, 1'b1, 1'b0, 1'b0, 8'h7C},
      '{2'd1, 8'hF8, 8'h78, 1'b0, 1'b0, 1'b0, 8'h00},
      '{2'd2, 8'h80, 8'hF8, 1'b1, 1'b0, 1'b0, 8'h7C},
      '{2'd2, 8'h79, 8'h38, 1'b0, 1'b0, 1'b1, 8'h7C},
      '{2'd3, 8'h38, 8'h80, 1'b0, 1'b1, 1'b0, 8'hF8},
      '{2'd3, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 8'h7C},
      '{2'd3, 8'h78, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}
    };
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      checks++;
      if ({bus.OUT_VALID, bus.OP_IS_EXCEPTION, bus.FLAG_INVALID, bus.FLAG_DIVZERO,
           bus.FLAG_NAN_IN, bus.RESULT_DEFAULT} !==
          {1'b1, vecs[i].inv | vecs[i].dz | vecs[i].nan, vecs[i].inv, vecs[i].dz,
           vecs[i].nan, vecs[i].res}) begin
        errors++;
        $display("FAIL directed_%0d: got v=%b x=%b i=%b d=%b n=%b r=%h want i=%b d=%b n=%b r=%h",
                 i, bus.OUT_VALID, bus.OP_IS_EXCEPTION, bus.FLAG_INVALID, bus.FLAG_DIVZERO,
                 bus.FLAG_NAN_IN, bus.RESULT_DEFAULT, vecs[i].inv, vecs[i].dz, vecs[i].nan,
                 vecs[i].res);
      end
    end
    idle();
    checks++;
    if ({bus.STICKY_FLAGS, bus.EXC_COUNT} !== {3'b111, 8'd6}) begin
      errors++;
      $display("FAIL directed_status: got sticky=%b count=%0d want sticky=111 count=6",
               bus.STICKY_FLAGS, bus.EXC_COUNT);
    end
  endtask

  task automatic test_backpressure();
    obs_t held;
    do_reset();
    drive(1'b1, 1'b0, 2'd0, 8'h78, 8'hF8);
    @(negedge clk);
    held = pack(1, 0, 1, 0, 0, 8'h7C, 3'b001, 8'd1);
    drive(1'b1, 1'b0, 2'd3, 8'h38, 8'h80);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== held) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got %h want %h", i, obs(), held);
      end
      @(negedge clk);
    end
    bus.OUT_READY = 1'b1;
    #1;
    checks++;
    if (bus.IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ready: got %b want 1", bus.IN_READY);
    end
    @(negedge clk);
    checks++;
    if (obs() !== pack(1, 1, 0, 1, 0, 8'hF8, 3'b011, 8'd2)) begin
      errors++;
      $display("FAIL backpressure_second: got %h want %h", obs(), pack(1, 1, 0, 1, 0, 8'hF8, 3'b011, 8'd2));
    end
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== pack(0, 1, 0, 1, 0, 8'hF8, 3'b011, 8'd2)) begin
      errors++;
      $display("FAIL backpressure_drain: got %h want %h", obs(), pack(0, 1, 0, 1, 0, 8'hF8, 3'b011, 8'd2));
    end
    idle();
  endtask

  task automatic test_back_to_back();
    ref_t exp_r;
    int cnt;
    logic [2:0] st;
    logic [1:0] op;
    logic [7:0] a, b;
    do_reset();
    cnt = 0;
    st = 3'b000;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      drive(1'b1, 1'b1, op, a, b);
      exp_r = ref_model(int'(op), int'(a), int'(b));
      st = st | {exp_r.nan, exp_r.dz, exp_r.inv};
      if (exp_r.nan || exp_r.dz || exp_r.inv) cnt++;
      @(negedge clk);
      checks++;
      if (obs() !== pack(1, 1, exp_r.inv, exp_r.dz, exp_r.nan, exp_r.res, st, 8'(cnt))) begin
        errors++;
        $display("FAIL back_to_back_%0d: op=%0d a=%h b=%h got %h want %h", i, op, a, b, obs(),
                 pack(1, 1, exp_r.inv, exp_r.dz, exp_r.nan, exp_r.res, st, 8'(cnt)));
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus2.IN_VALID = 1'b1; bus2.OUT_READY = 1'b1; bus2.FP_OPERATION = 2'd0;
      bus2.OP_A = 8'h78; bus2.OP_B = 8'hF8;
      @(negedge clk);
      checks++;
      if ({bus2.STICKY_FLAGS, bus2.EXC_COUNT} !== {3'b001, 2'((i + 1 > 3) ? 3 : i + 1)}) begin
        errors++;
        $display("FAIL saturate_%0d: got sticky=%b count=%0d want sticky=001 count=%0d",
                 i, bus2.STICKY_FLAGS, bus2.EXC_COUNT, (i + 1 > 3) ? 3 : i + 1);
      end
    end
    bus2.FP_OPERATION = 2'd3; bus2.OP_A = 8'h38; bus2.OP_B = 8'h00; bus2.CLR_STICKY = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus2.STICKY_FLAGS, bus2.EXC_COUNT, bus2.FLAG_DIVZERO} !== {3'b010, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL clear_with_exception: got sticky=%b count=%0d dz=%b want sticky=010 count=1 dz=1",
               bus2.STICKY_FLAGS, bus2.EXC_COUNT, bus2.FLAG_DIVZERO);
    end
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(1'b1, 1'b1, 2'd2, 8'h79, 8'h38);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 8'h78, 8'hF8);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd3, 8'h38, 8'h80);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd1, 8'hF8, 8'hF8);
    @(negedge clk);
    checks++;
    if ({bus.OUT_VALID, bus.IN_READY, bus.STICKY_FLAGS, bus.EXC_COUNT} !== {1'b1, 1'b0, 3'b111, 8'd3}) begin
      errors++;
      $display("FAIL pre_reset_state: got v=%b r=%b sticky=%b count=%0d want v=1 r=0 sticky=111 count=3",
               bus.OUT_VALID, bus.IN_READY, bus.STICKY_FLAGS, bus.EXC_COUNT);
    end
    rst = 1'b1;
    bus.CLR_STICKY = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 8'h78, 8'hF8);
    @(negedge clk);
    rst = 1'b0;
    idle();
    checks++;
    if (obs() !== pack(0, 1, 0, 0, 0, 8'h00, 3'b000, 8'h00)) begin
      errors++;
      $display("FAIL reset_midflight: got %h want %h", obs(), pack(0, 1, 0, 0, 0, 8'h00, 3'b000, 8'h00));
    end
  endtask

  task automatic test_random();
    logic v, rdy, clr, m_rdy, accept;
    logic [1:0] op;
    logic [7:0] a, b;
    ref_t r;
    do_reset();
    m_valid = 1'b0; m_out = '0; m_sticky = 3'b000; m_cnt = 0;
    rdy = 1'b0;
    for (int i = 0; i < 500; i++) begin
      checks++;
      if (obs() !== pack(m_valid, !m_valid || rdy, m_out.inv, m_out.dz, m_out.nan, m_out.res,
                         m_sticky, 8'(m_cnt))) begin
        errors++;
        $display("FAIL random_state_%0d: got %h want %h", i, obs(),
                 pack(m_valid, !m_valid || rdy, m_out.inv, m_out.dz, m_out.nan, m_out.res,
                      m_sticky, 8'(m_cnt)));
      end
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      op  = 2'($urandom_range(0, 3));
      a   = pick_operand();
      b   = pick_operand();
      drive(v, rdy, op, a, b);
      bus.CLR_STICKY = clr;
      m_rdy  = !m_valid || rdy;
      accept = v && m_rdy;
      #1;
      checks++;
      if (bus.IN_READY !== m_rdy) begin
        errors++;
        $display("FAIL random_ready_%0d: got %b want %b", i, bus.IN_READY, m_rdy);
      end
      if (clr) begin
        m_sticky = 3'b000;
        m_cnt = 0;
      end
      if (accept) begin
        r = ref_model(int'(op), int'(a), int'(b));
        m_out = r;
        m_valid = 1'b1;
        m_sticky = m_sticky | {r.nan, r.dz, r.inv};
        if ((r.nan || r.dz || r.inv) && m_cnt < CMAX) m_cnt++;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
